store_buffer: RTL and testbench

//   Posted-write FIFO between the store stage and data memory. It accepts

---
 rtl/store_buffer.sv | 91 +++++++++
 tb/tb_store_buffer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the store stage and data memory,
// with youngest-match forwarding of pending words to the lookup path.
//   clock, reset                 rising-edge clock, async active-high reset
//   push_valid/ready/address/value   store-stage write request (word granular)
//   mem_write_enable/ready/address/value   in-order drain to data memory
//   lookup_address/hit/value     combinational forwarding of the youngest pending word
//   count, full, empty           occupancy status
module store_buffer #(
   parameter int DEPTH      = 4,
   parameter int PTR_WIDTH  = 2,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  push_valid,
   output logic                  push_ready,
   input  logic [ADDR_WIDTH-1:0] push_address,
   input  logic [DATA_WIDTH-1:0] push_value,
   output logic                  mem_write_enable,
   input  logic                  mem_write_ready,
   output logic [ADDR_WIDTH-1:0] mem_write_address,
   output logic [DATA_WIDTH-1:0] mem_write_value,
   input  logic [ADDR_WIDTH-1:0] lookup_address,
   output logic                  lookup_hit,
   output logic [DATA_WIDTH-1:0] lookup_value,
   output logic [PTR_WIDTH:0]    count,
   output logic                  full,
   output logic                  empty
);
   logic [ADDR_WIDTH-3:0] r_addr [DEPTH];
   logic [DATA_WIDTH-1:0] r_data [DEPTH];
   logic [PTR_WIDTH-1:0]  r_wptr;
   logic [PTR_WIDTH-1:0]  r_rptr;
   logic [PTR_WIDTH:0]    r_count;
   logic                  w_push;
   logic                  w_pop;
   logic [PTR_WIDTH-1:0]  w_idx;
   logic                  w_hit;
   logic [DATA_WIDTH-1:0] w_val;
   logic                  w_unused;

   // Byte-offset bits never matter: storage and matching are per word.
   assign w_unused          = ^{push_address[1:0], lookup_address[1:0]};
   assign full              = r_count == (PTR_WIDTH+1)'(DEPTH);
   assign empty             = r_count == '0;
   assign push_ready        = !full;
   assign mem_write_enable  = !empty;
   assign w_push            = push_valid && push_ready;
   assign w_pop             = mem_write_enable && mem_write_ready;
   assign mem_write_address = {r_addr[r_rptr], 2'b00};
   assign mem_write_value   = r_data[r_rptr];
   assign count             = r_count;
   assign lookup_hit        = w_hit;
   assign lookup_value      = w_val;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_WIDTH'(1);
         if (w_pop) r_rptr <= r_rptr + PTR_WIDTH'(1);
         r_count <= r_count + {{PTR_WIDTH{1'b0}}, w_push} - {{PTR_WIDTH{1'b0}}, w_pop};
      end
   end

   // Payload needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_addr[r_wptr] <= push_address[ADDR_WIDTH-1:2];
         r_data[r_wptr] <= push_value;
      end
   end

   // Walk oldest to youngest from the head so a later match overrides an
   // earlier one; this keeps age order correct across pointer wrap.
   always_comb begin
      w_hit = 1'b0;
      w_val = '0;
      w_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_idx = r_rptr + PTR_WIDTH'(i);
         if ((PTR_WIDTH+1)'(i) < r_count && r_addr[w_idx] == lookup_address[ADDR_WIDTH-1:2]) begin
            w_hit = 1'b1;
            w_val = r_data[w_idx];
         end
      end
   end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: randomized and directed check of store_buffer against a queue model.
module tb_store_buffer;
   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } ent_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        push_valid = 1'b0;
   logic        push_ready;
   logic [31:0] push_address = '0;
   logic [31:0] push_value = '0;
   logic        mem_write_enable;
   logic        mem_write_ready = 1'b0;
   logic [31:0] mem_write_address;
   logic [31:0] mem_write_value;
   logic [31:0] lookup_address = '0;
   logic        lookup_hit;
   logic [31:0] lookup_value;
   logic [2:0]  count;
   logic        full;
   logic        empty;

   ent_t q[$];
   int n_chk = 0;
   int n_fail = 0;
   int n_pop = 0;

   store_buffer dut (
      .clock(clock), .reset(reset),
      .push_valid(push_valid), .push_ready(push_ready),
      .push_address(push_address), .push_value(push_value),
      .mem_write_enable(mem_write_enable), .mem_write_ready(mem_write_ready),
      .mem_write_address(mem_write_address), .mem_write_value(mem_write_value),
      .lookup_address(lookup_address), .lookup_hit(lookup_hit), .lookup_value(lookup_value),
      .count(count), .full(full), .empty(empty)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic check_outputs();
      bit          h = 1'b0;
      logic [31:0] v = '0;
      int          n = q.size();
      for (int i = 0; i < n; i++)
         if (q[i].a[31:2] == lookup_address[31:2]) begin
            h = 1'b1;
            v = q[i].d;
         end
      chk("count", 64'(count), 64'(n));
      chk("full", 64'(full), 64'(n == 4));
      chk("empty", 64'(empty), 64'(n == 0));
      chk("push_ready", 64'(push_ready), 64'(n != 4));
      chk("mem_we", 64'(mem_write_enable), 64'(n != 0));
      chk("hit", 64'(lookup_hit), 64'(h));
      chk("lookup_value", 64'(lookup_value), 64'(v));
      if (n != 0) begin
         chk("mem_addr", 64'(mem_write_address), 64'(q[0].a));
         chk("mem_data", 64'(mem_write_value), 64'(q[0].d));
      end
   endtask

   // Inputs are set at posedge+1; outputs are checked at posedge+3.
   task automatic cycle();
      bit pv, pp;
      #2;
      check_outputs();
      @(posedge clock);
      pv = push_valid && q.size() < 4;
      pp = q.size() > 0 && mem_write_ready;
      if (pp) begin
         void'(q.pop_front());
         n_pop++;
      end
      if (pv) q.push_back('{push_address & ~32'h3, push_value});
      #1;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d, input logic rdy);
      push_valid = 1'b1;
      push_address = a;
      push_value = d;
      mem_write_ready = rdy;
      cycle();
      push_valid = 1'b0;
   endtask

   task automatic drain();
      push_valid = 1'b0;
      mem_write_ready = 1'b1;
      for (int k = 0; k < 20 && q.size() > 0; k++) cycle();
      chk("drain_done", 64'(q.size()), 64'd0);
      mem_write_ready = 1'b0;
   endtask

   initial begin
      int base, idx, guard;
      #12 reset = 1'b0;
      @(posedge clock);
      #1;
      cycle();
      chk("reset_empty", 64'(empty), 64'd1);
      chk("reset_mwe", 64'(mem_write_enable), 64'd0);

      push(32'h100, 32'hDEADBEEF, 1'b0);
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk("hold_addr", 64'(mem_write_address), 64'h100);
         chk("hold_data", 64'(mem_write_value), 64'hDEADBEEF);
      end
      mem_write_ready = 1'b1;
      cycle();
      mem_write_ready = 1'b0;
      #2;
      chk("popped_empty", 64'(empty), 64'd1);

      for (int k = 0; k < 4; k++) push(32'(4 * k), 32'hA0 + 32'(k), 1'b0);
      #2;
      chk("full_flag", 64'(full), 64'd1);
      chk("full_ready", 64'(push_ready), 64'd0);
      push(32'h10, 32'hBAD, 1'b1);
      #2;
      chk("fifth_rejected", 64'(count), 64'd3);
      drain();

      push(32'h200, 32'h11111111, 1'b0);
      push(32'h202, 32'h22222222, 1'b0);
      lookup_address = 32'h203;
      #2;
      chk("fwd_hit", 64'(lookup_hit), 64'd1);
      chk("fwd_value", 64'(lookup_value), 64'h22222222);
      lookup_address = 32'h204;
      #2;
      chk("fwd_miss", 64'(lookup_hit), 64'd0);
      cycle();
      drain();

      base = n_pop;
      idx = 0;
      guard = 0;
      while (idx < 10 && guard < 100) begin
         if (q.size() < 4) push(32'h400 + 32'(4 * idx), 32'(idx), guard[0]);
         else begin
            mem_write_ready = guard[0];
            cycle();
         end
         if (guard[0] == 1'b0 || q.size() < 4) idx = idx;
         guard++;
         idx = n_pop - base + q.size();
      end
      drain();
      chk("wrap_pops", 64'(n_pop - base), 64'd10);
      chk("wrap_count", 64'(count), 64'd0);

      for (int k = 0; k < 400; k++) begin
         push_valid = 1'($urandom_range(0, 1));
         push_address = 32'h300 + 32'($urandom_range(0, 4) * 4) + 32'($urandom_range(0, 3));
         push_value = $urandom;
         mem_write_ready = ($urandom_range(0, 2) == 0);
         lookup_address = 32'h300 + 32'($urandom_range(0, 4) * 4) + 32'($urandom_range(0, 3));
         cycle();
      end
      drain();

      for (int k = 0; k < 3; k++) push(32'h500 + 32'(4 * k), 32'h50 + 32'(k), 1'b0);
      mem_write_ready = 1'b1;
      #2 reset = 1'b1;
      #1;
      chk("async_mwe", 64'(mem_write_enable), 64'd0);
      chk("async_count", 64'(count), 64'd0);
      chk("async_empty", 64'(empty), 64'd1);
      q.delete();
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
      base = n_pop;
      for (int k = 0; k < 5; k++) cycle();
      chk("no_writes_after_reset", 64'(n_pop - base), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
